// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit ripple slice reused WIDTH/CHUNK times,
// LSB chunk first, with a registered carry between chunks and a start/busy/done handshake.
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_accept;
    logic             w_msb_carry;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_k == KW'(N - 1));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_a_chunk  = '0;
        w_b_chunk  = '0;
        w_res_next = r_res;
        for (int j = 0; j < N; j++) begin
            if (r_k == KW'(j)) begin
                w_a_chunk = r_a[j*CHUNK +: CHUNK];
                w_b_chunk = r_b[j*CHUNK +: CHUNK];
            end
        end
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        for (int j = 0; j < N; j++) begin
            if (r_k == KW'(j)) begin
                w_res_next[j*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
            end
        end
    end

    // Carry into the top bit of the slice, recovered from that bit's sum and operands.
    assign w_msb_carry = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_k     <= '0;
            r_res   <= '0;
        end else if (r_state == S_RUN) begin
            r_res   <= w_res_next;
            r_carry <= w_chunk_sum[CHUNK];
            r_k     <= r_k + KW'(1);
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_chunk_sum[CHUNK];
                r_ovf  <= w_msb_carry ^ w_chunk_sum[CHUNK];
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: a 16/4 instance and an 8/8 single-pass instance,
// checked against an arithmetic reference model by decoupled done-triggered monitors.
module tb_multicycle_adder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start16, sub16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clock(clock), .reset_n(reset_n), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
        .overflow(ovf16)
    );

    multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .overflow(ovf8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer add/subtract, then reduce modulo 2^w and range-check the signed value.
    function automatic exp_t model(input int w, input longint ua, input longint ub,
                                   input bit s, input bit c, input int due);
        exp_t   m;
        longint span = longint'(1) <<< w;
        longint half = longint'(1) <<< (w - 1);
        longint sa   = (ua >= half) ? ua - span : ua;
        longint sb   = (ub >= half) ? ub - span : ub;
        longint full;
        longint sres;
        if (!s) begin
            full   = ua + ub + longint'(c);
            m.cout = (full >= span);
            sres   = sa + sb + longint'(c);
        end else begin
            full   = ua - ub - longint'(c);
            m.cout = (full >= 0);
            sres   = sa - sb - longint'(c);
        end
        m.sum = 64'(full) & 64'(span - 1);
        m.ovf = (sres >= half) || (sres < -half);
        m.due = due;
        return m;
    endfunction

    // Entered and left on a falling edge; starts one operation as soon as the unit is not busy.
    task automatic issue(input bit w8, input logic [15:0] a, input logic [15:0] b,
                         input bit s, input bit c, input bit push, input bit inject);
        int     budget = 200;
        longint ua     = w8 ? longint'(a[7:0]) : longint'(a);
        longint ub     = w8 ? longint'(b[7:0]) : longint'(b);
        while ((w8 ? busy8 : busy16) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (budget == 0) check(w8 ? "busy8_timeout" : "busy16_timeout", w8 ? busy8 : busy16, 0);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; sub8 = s; cin8 = c; start8 = 1'b1;
            if (push) q8.push_back(model(8, ua, ub, s, c, cyc + 2));
        end else begin
            a16 = a; b16 = b; sub16 = s; cin16 = c; start16 = 1'b1;
            if (push) q16.push_back(model(16, ua, ub, s, c, cyc + 5));
        end
        @(negedge clock);
        start16 = 1'b0;
        start8  = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); cin16 = 1'($urandom);
        a8  = 8'($urandom);  b8  = 8'($urandom);  sub8  = 1'($urandom); cin8  = 1'($urandom);
        if (inject) begin
            start16 = 1'b1;
            @(negedge clock);
            start16 = 1'b0;
        end
    endtask

    task automatic drain();
        int budget = 300;
        while ((q16.size() != 0 || q8.size() != 0 || busy16 || busy8 || done16 || done8)
               && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check("drain_q16", 64'(q16.size()), 0);
        check("drain_q8", 64'(q8.size()), 0);
    endtask

    always @(negedge clock) begin : mon16
        exp_t e;
        if (reset_n && done16) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", done16, 0);
            end else begin
                e = q16.pop_front();
                check("sum16", sum16, e.sum);
                check("cout16", cout16, e.cout);
                check("ovf16", ovf16, e.ovf);
                check("latency16", 64'(cyc), 64'(e.due));
                check("busy16_at_done", busy16, 0);
            end
        end
    end

    always @(negedge clock) begin : mon8
        exp_t e;
        if (reset_n && done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", done8, 0);
            end else begin
                e = q8.pop_front();
                check("sum8", sum8, e.sum);
                check("cout8", cout8, e.cout);
                check("ovf8", ovf8, e.ovf);
                check("latency8", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; sub8  = 1'b0; cin8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy16", busy16, 0);
        check("rst_done16", done16, 0);
        check("rst_sum16", sum16, 0);
        check("rst_cout16", cout16, 0);
        check("rst_ovf16", ovf16, 0);
        check("rst_busy8", busy8, 0);
        check("rst_sum8", sum8, 0);
        reset_n = 1'b1;
        @(negedge clock);

        issue(0, 16'h1234, 16'h4321, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            check("busy16_run", busy16, 1);
            @(negedge clock);
        end
        check("busy16_after_run", busy16, 0);

        issue(0, 16'hFFFF, 16'h0001, 0, 0, 1, 0);
        issue(0, 16'h7FFF, 16'h0001, 0, 0, 1, 0);
        issue(0, 16'h0005, 16'h0007, 1, 0, 1, 0);
        issue(0, 16'h8000, 16'h0001, 1, 0, 1, 0);
        issue(0, 16'h0010, 16'h0001, 1, 1, 1, 0);
        issue(0, 16'hABCD, 16'h1234, 0, 1, 1, 1);
        issue(0, 16'h0000, 16'h8000, 1, 0, 1, 0);
        for (int i = 0; i < 30; i++) begin
            issue(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1,
                  ($urandom_range(0, 3) == 0));
        end
        drain();

        issue(0, 16'h1111, 16'h2222, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("abort_busy16", busy16, 0);
        check("abort_done16", done16, 0);
        check("abort_sum16", sum16, 0);
        check("abort_cout16", cout16, 0);
        check("abort_ovf16", ovf16, 0);
        repeat (6) @(negedge clock);
        issue(0, 16'h0F0F, 16'h00F1, 1, 0, 1, 0);
        drain();

        issue(1, 16'h007F, 16'h0001, 0, 0, 1, 0);
        issue(1, 16'h0080, 16'h0001, 1, 0, 1, 0);
        issue(1, 16'h00FF, 16'h00FF, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            issue(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1, 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised, multi-cycle add/subtract unit built from a single CHUNK-bit ripple adder slice.
- The slice is reused over WIDTH/CHUNK clock cycles, LSB chunk first, with a registered carry between chunks.
- Start/busy/done handshake; sum, carry-out and signed overflow are held until the next operation.
- Used by datapaths that need wide add/sub without a WIDTH-bit combinational ripple path.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; CHUNK = WIDTH gives a single-pass adder.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b+cin, 1 = a-b-cin; latched at start.
- cin  in  1  carry-in (add) or borrow-in (sub); latched at start.
- a  in  WIDTH  operand A; latched at start.
- b  in  WIDTH  operand B; latched at start.
- busy  out  1  high while chunks are being processed (RUN).
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result; registered and held.
- cout  out  1  raw carry out of the MSB; in sub mode 1 = no borrow.
- overflow  out  1  two's-complement overflow of the result.

Behaviour:
- Reset (reset_n = 0 at an edge): state IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; internal registers cleared. Applies in any state and aborts an operation in progress, with no done pulse.
- N = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge E0:
  - Latch A=a and B' = sub ? ~b : b.
  - Set carry = cin XOR sub, chunk index k=0.
  - Go to RUN; busy=1 from E0.
- RUN, each edge E1..EN:
  - Compute A[k] + B'[k] + carry with the CHUNK-bit adder.
  - Write the chunk sum into the internal result register at position k.
  - Carry register takes the chunk carry-out; k increments.
  - On the chunk where k = N-1, also record the carry into the MSB, i.e. the carry out of bit WIDTH-2.
- At EN: copy the internal result to sum, cout = final carry, and overflow = carry into MSB XOR cout. Go to DONE with busy=0 and done=1.
- DONE lasts one cycle, then returns to IDLE (done=0). If start=1 during DONE, a new operation begins at that edge, exactly as from IDLE.
- Latency: done is high in the cycle following EN, i.e. N+1 edges after the start sample. Back-to-back throughput is one result per N+1 cycles.
- start while busy=1 is ignored; latched operands, sub and cin are unaffected.
- sum, cout and overflow change only at EN (or at reset). Partial results are never visible on the outputs.
- a, b, sub and cin are don't-care outside the start edge.
- CHUNK = WIDTH (N=1): RUN lasts one edge. The MSB-carry tap still applies when WIDTH >= 2.
- Width rule: sum is modulo 2^WIDTH; no sign extension or saturation.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- 0x1234 + 0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, overflow=0; done exactly 5 edges after the start edge; busy high for 4 cycles.
- 0xFFFF + 0x0001 -> sum=0x0000, cout=1, overflow=0. Then 0x7FFF + 0x0001 -> sum=0x8000, cout=0, overflow=1.
- sub=1: 0x0005 - 0x0007 -> sum=0xFFFE, cout=0. Then 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, overflow=1. Then sub=1, cin=1, 0x0010 - 0x0001 -> sum=0x000E.
- Start pulse during RUN with different operands -> ignored; the original result is delivered. Start asserted in the DONE cycle -> the second operation completes 5 edges later with the correct result.
- reset_n=0 for one edge at the second RUN cycle -> busy=0, sum=0, no done pulse. The next start produces a correct result.
- WIDTH=8, CHUNK=8: 0x7F + 0x01 -> sum=0x80, overflow=1; done 2 edges after start.
